pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives hold/bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB segment registers, including exe_stall and int_flush consumed by the EX/MEM register.
- Resolves load-use hazards, multi-cycle HI/LO divide occupancy, data-SRAM wait states and CP0 exception/eret flushes under one fixed priority.

Parameters:
- DIV_CYCLES, 33: cycles a div/divu occupies EX, minimum 1.
- CNT_W, 6: divide counter width; must hold DIV_CYCLES-1.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- load_use  in  1  ID instruction reads rd of load currently in EX
- div_start  in  1  EX holds div/divu; level, held while instruction sits in EX
- mem_req  in  1  MEM stage holds load/store issuing a data-SRAM request
- data_ok  in  1  data-SRAM response for current request
- mem_cp0_ex  in  1  exception committed by MEM-stage instruction
- mem_eret  in  1  eret committed by MEM-stage instruction
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- idex_stall  out  1  hold ID/EX
- idex_bubble  out  1  clear ID/EX (insert nop)
- exe_stall  out  1  clear EX/MEM (insert nop)
- exmem_hold  out  1  hold EX/MEM contents
- wb_bubble  out  1  clear MEM/WB
- int_flush  out  1  flush IF/ID, ID/EX, EX/MEM; redirect PC
- div_done  out  1  1-cycle pulse: divide result valid, EX advances
- div_busy  out  1  divide in progress

Behaviour:
- State register: RUN, DIV, MEMW. Counter cnt[CNT_W-1:0]. Pending flag pend_exc.
- All outputs are combinational from state, cnt and inputs.
- While resetn=0, all outputs are forced to 0. On the clock edge with resetn=0: state<=RUN, cnt<=0, pend_exc<=0.
- exc = mem_cp0_ex | mem_eret.
- RUN, priority (highest first):
  - (1) exc: int_flush=1, all other outputs 0; state stays RUN; cnt<=0.
  - (2) mem_req & ~data_ok: pc/ifid/idex_stall=1, exmem_hold=1, wb_bubble=1; state<=MEMW.
  - (3) div_start: pc/ifid/idex_stall=1, exe_stall=1, div_busy=1; cnt<=DIV_CYCLES-1; state<=DIV.
  - (4) load_use: pc_stall=ifid_stall=1, idex_bubble=1 for that cycle only; no state change.
  - (5) else: all outputs 0.
- mem_req & data_ok in the same RUN cycle causes no stall.
- DIV:
  - div_busy=1 throughout.
  - cnt!=0: pc/ifid/idex_stall=1, exe_stall=1; cnt<=cnt-1.
  - cnt==0: div_done=1, no stalls; state<=RUN.
  - Total stalled cycles = DIV_CYCLES. div_done occurs DIV_CYCLES cycles after div_start is first seen.
  - exc in DIV (older instruction in MEM): int_flush=1, divide aborted, div_busy=0, no div_done, cnt<=0, state<=RUN.
  - div_start and load_use are ignored while in DIV.
- MEMW:
  - pc/ifid/idex_stall=1, exmem_hold=1, wb_bubble=1 until data_ok.
  - Cycle with data_ok: all stalls 0; state<=RUN.
  - A bus transaction is never aborted. exc seen in MEMW sets pend_exc<=1.
  - int_flush is asserted in the data_ok cycle if pend_exc | exc, then pend_exc<=0.
- div_start coinciding with a MEMW entry is not lost: it stays asserted and is serviced on return to RUN.
- A 1-cycle int_flush leaves the pipeline empty; the next cycle's inputs are evaluated normally.
- DIV_CYCLES=1: DIV is entered with cnt=0, so div_done fires the next cycle and exactly 1 stall cycle results.

Test Plan:
- Reset: hold resetn=0 for 2 cycles with all inputs=1 -> every output 0; after release, state RUN, cnt=0.
- Load-use: load_use=1 for 1 cycle in RUN -> pc_stall=ifid_stall=idex_bubble=1 that cycle only; exe_stall=0.
- Divide, DIV_CYCLES=33: div_start held from cycle T -> stalls and exe_stall high T..T+32; div_done=1 and stalls 0 at T+33; div_start remaining high at T+33 does not restart the divide.
- Exception mid-divide: mem_cp0_ex=1 at T+10 -> int_flush=1 at T+10; div_busy=0 and no div_done afterwards; next cycle RUN with no stalls.
- Memory wait: mem_req=1, data_ok=0 for 4 cycles, then 1 -> exmem_hold=wb_bubble=1 for 4 cycles, 0 in the data_ok cycle. Simultaneous div_start=1 enters DIV on the following cycle.
- Exception during MEMW: mem_eret pulse in the 2nd wait cycle, data_ok in the 4th -> int_flush=1 only in the data_ok cycle, pend_exc cleared.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline.
// Arbitrates exceptions/eret, data-SRAM wait states, multi-cycle divides
// and load-use hazards under one fixed priority.
// Outputs are combinational from state, counter and the current inputs.
module pipe_hazard_ctrl #(
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned CNT_W      = 6
) (
  input  logic clk,
  input  logic resetn,
  input  logic load_use,
  input  logic div_start,
  input  logic mem_req,
  input  logic data_ok,
  input  logic mem_cp0_ex,
  input  logic mem_eret,
  output logic pc_stall,
  output logic ifid_stall,
  output logic idex_stall,
  output logic idex_bubble,
  output logic exe_stall,
  output logic exmem_hold,
  output logic wb_bubble,
  output logic int_flush,
  output logic div_done,
  output logic div_busy
);

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] MEMW = 2'd2;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pend_exc, pend_nxt;
  logic             exc;

  assign exc = mem_cp0_ex | mem_eret;

  // Output decode and next-state selection; everything stays low in reset.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    idex_bubble = 1'b0;
    exe_stall   = 1'b0;
    exmem_hold  = 1'b0;
    wb_bubble   = 1'b0;
    int_flush   = 1'b0;
    div_done    = 1'b0;
    div_busy    = 1'b0;
    state_nxt   = state;
    cnt_nxt     = cnt;
    pend_nxt    = pend_exc;
    if (resetn) begin
      case (state)
        RUN: begin
          if (exc) begin
            int_flush = 1'b1;
            cnt_nxt   = '0;
          end else if (mem_req && !data_ok) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_stall = 1'b1;
            exmem_hold = 1'b1;
            wb_bubble  = 1'b1;
            state_nxt  = MEMW;
          end else if (div_start) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_stall = 1'b1;
            exe_stall  = 1'b1;
            div_busy   = 1'b1;
            cnt_nxt    = DIV_LAST;
            state_nxt  = DIV;
          end else if (load_use) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
          end
        end
        DIV: begin
          if (exc) begin
            // Older instruction in MEM traps: abandon the divide outright.
            int_flush = 1'b1;
            cnt_nxt   = '0;
            state_nxt = RUN;
          end else if (cnt != '0) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_stall = 1'b1;
            exe_stall  = 1'b1;
            div_busy   = 1'b1;
            cnt_nxt    = cnt - CNT_W'(1);
          end else begin
            div_busy  = 1'b1;
            div_done  = 1'b1;
            state_nxt = RUN;
          end
        end
        MEMW: begin
          if (data_ok) begin
            // The bus transaction finishes first; a trap seen while waiting
            // is released as a flush in the completion cycle.
            int_flush = pend_exc | exc;
            pend_nxt  = 1'b0;
            state_nxt = RUN;
          end else begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_stall = 1'b1;
            exmem_hold = 1'b1;
            wb_bubble  = 1'b1;
            if (exc) pend_nxt = 1'b1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // State, divide counter and pending-exception register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= RUN;
      cnt      <= '0;
      pend_exc <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pend_exc <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (DIV_CYCLES=33 main instance,
// plus a DIV_CYCLES=1 instance for the single-cycle divide boundary).
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic resetn, load_use, div_start, mem_req, data_ok, mem_cp0_ex, mem_eret;

  logic pc_stall, ifid_stall, idex_stall, idex_bubble, exe_stall;
  logic exmem_hold, wb_bubble, int_flush, div_done, div_busy;
  logic pc_stall1, ifid_stall1, idex_stall1, idex_bubble1, exe_stall1;
  logic exmem_hold1, wb_bubble1, int_flush1, div_done1, div_busy1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Output bit order: pc ifid idex idex_bubble exe_stall exmem_hold wb_bubble
  //                   int_flush div_done div_busy
  logic [9:0] outs, outs1;
  assign outs  = {pc_stall, ifid_stall, idex_stall, idex_bubble, exe_stall,
                  exmem_hold, wb_bubble, int_flush, div_done, div_busy};
  assign outs1 = {pc_stall1, ifid_stall1, idex_stall1, idex_bubble1, exe_stall1,
                  exmem_hold1, wb_bubble1, int_flush1, div_done1, div_busy1};

  localparam logic [9:0] O_NONE  = 10'b0000000000;
  localparam logic [9:0] O_LU    = 10'b1101000000;
  localparam logic [9:0] O_DIV   = 10'b1110100001;
  localparam logic [9:0] O_MEMW  = 10'b1110011000;
  localparam logic [9:0] O_FLUSH = 10'b0000000100;
  localparam logic [9:0] O_DONE  = 10'b0000000011;

  // Input bit order: resetn load_use div_start mem_req data_ok mem_cp0_ex mem_eret
  localparam logic [6:0] I_IDLE = 7'b1000000;
  localparam logic [6:0] I_LU   = 7'b1100000;
  localparam logic [6:0] I_DIV  = 7'b1010000;
  localparam logic [6:0] I_WAIT = 7'b1001000;
  localparam logic [6:0] I_OK   = 7'b1001100;

  pipe_hazard_ctrl #(.DIV_CYCLES(33), .CNT_W(6)) dut (
    .clk(clk), .resetn(resetn), .load_use(load_use), .div_start(div_start),
    .mem_req(mem_req), .data_ok(data_ok), .mem_cp0_ex(mem_cp0_ex),
    .mem_eret(mem_eret), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .idex_stall(idex_stall), .idex_bubble(idex_bubble), .exe_stall(exe_stall),
    .exmem_hold(exmem_hold), .wb_bubble(wb_bubble), .int_flush(int_flush),
    .div_done(div_done), .div_busy(div_busy)
  );

  pipe_hazard_ctrl #(.DIV_CYCLES(1), .CNT_W(1)) dut1 (
    .clk(clk), .resetn(resetn), .load_use(load_use), .div_start(div_start),
    .mem_req(mem_req), .data_ok(data_ok), .mem_cp0_ex(mem_cp0_ex),
    .mem_eret(mem_eret), .pc_stall(pc_stall1), .ifid_stall(ifid_stall1),
    .idex_stall(idex_stall1), .idex_bubble(idex_bubble1), .exe_stall(exe_stall1),
    .exmem_hold(exmem_hold1), .wb_bubble(wb_bubble1), .int_flush(int_flush1),
    .div_done(div_done1), .div_busy(div_busy1)
  );

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic set_in(input logic [6:0] v);
    {resetn, load_use, div_start, mem_req, data_ok, mem_cp0_ex, mem_eret} = v;
  endtask

  // Apply one cycle of inputs, check the main instance mid-cycle, advance.
  task automatic vec(input string tag, input logic [6:0] in, input logic [9:0] exp);
    set_in(in);
    #1;
    check(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_in(7'b0111111);
    #1;

    // Reset with every input high: all outputs forced low.
    vec("reset_c0", 7'b0111111, O_NONE);
    vec("reset_c1", 7'b0111111, O_NONE);
    vec("post_reset_idle", I_IDLE, O_NONE);

    // Load-use: one-cycle stall plus bubble, nothing sticky.
    vec("load_use", I_LU, O_LU);
    vec("load_use_after", I_IDLE, O_NONE);

    // Same-cycle data_ok: no stall.
    vec("mem_hit", I_OK, O_NONE);

    // Full divide: 33 stalled cycles, done at T+33 despite div_start high.
    for (int unsigned i = 0; i < 33; i++) vec($sformatf("div_stall_%0d", i), I_DIV, O_DIV);
    vec("div_done", I_DIV, O_DONE);
    vec("div_after", I_IDLE, O_NONE);

    // Exception at T+10 of a divide aborts it.
    for (int unsigned i = 0; i < 10; i++) vec($sformatf("dexc_stall_%0d", i), I_DIV, O_DIV);
    vec("dexc_flush", 7'b1010010, O_FLUSH);
    for (int unsigned i = 0; i < 3; i++) vec($sformatf("dexc_idle_%0d", i), I_IDLE, O_NONE);

    // Exception beats a memory wait and a divide in RUN.
    vec("run_exc_prio", 7'b1011001, O_FLUSH);
    vec("run_exc_after", I_IDLE, O_NONE);

    // Memory wait with div_start held; divide starts after data_ok.
    for (int unsigned i = 0; i < 4; i++) vec($sformatf("memw_%0d", i), 7'b1011000, O_MEMW);
    vec("memw_ok", 7'b1011100, O_NONE);
    vec("memw_then_div", I_DIV, O_DIV);
    vec("div_ignores_lu", 7'b1110000, O_DIV);

    // Reset in the middle of a divide returns to RUN.
    vec("reset_mid_div", 7'b0111111, O_NONE);
    vec("reset_mid_div_idle", I_IDLE, O_NONE);
    vec("reset_mid_div_lu", I_LU, O_LU);

    // eret in 2nd wait cycle, data_ok in 4th: flush only on completion.
    vec("mexc_w1", I_WAIT, O_MEMW);
    vec("mexc_w2_eret", 7'b1001001, O_MEMW);
    vec("mexc_w3", I_WAIT, O_MEMW);
    vec("mexc_ok_flush", I_OK, O_FLUSH);
    vec("mexc_idle", I_IDLE, O_NONE);
    // Pending flag must have cleared.
    vec("mexc2_w1", I_WAIT, O_MEMW);
    vec("mexc2_ok", I_OK, O_NONE);

    // DIV_CYCLES=1 instance: exactly one stall cycle, then done.
    set_in(I_DIV);
    #1;
    check("div1_stall", outs1, O_DIV);
    @(posedge clk);
    #1;
    check("div1_done", outs1, O_DONE);
    @(posedge clk);
    #1;
    set_in(I_IDLE);
    #1;
    check("div1_after", outs1, O_NONE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
